vid_stream_framer: RTL

//  Receive-side companion to the scaler pixel stream: takes the unframed o_data/o_dvalid

---
 rtl/vid_stream_framer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vid_stream_framer.sv
// Re-frames the scaler's unframed pixel stream into SOF/EOL/EOF-marked pixels.
// Also reports frame completion, overflow pixels and idle-gap aborts.
module vid_stream_framer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 10,
  parameter int unsigned TW      = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [CW-1:0] i_width,
  input  logic [CW-1:0] i_height,
  input  logic [DW-1:0] i_data,
  input  logic          i_dvalid,
  output logic [DW-1:0] o_data,
  output logic          o_dvalid,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof,
  output logic          o_done,
  output logic          o_busy,
  output logic          o_err_ovf,
  output logic          o_err_timeout,
  output logic [CW-1:0] o_line_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_SAT  = TW'(TIMEOUT);

  state_t        state, state_next;
  logic [CW-1:0] w_m1, h_m1, x, y;
  logic [TW-1:0] idle_cnt;

  logic dims_ok, last_x, last_y;
  logic arm, clr_err, ovf, tmo, fwd, first, eol, eof;

  assign dims_ok = (i_width != '0) && (i_height != '0);
  assign last_x  = (x == w_m1);
  assign last_y  = (y == h_m1);
  assign o_busy  = (state != IDLE);

  always_comb begin
    state_next = state;
    arm        = 1'b0;
    clr_err    = 1'b0;
    ovf        = 1'b0;
    tmo        = 1'b0;
    fwd        = 1'b0;
    first      = 1'b0;
    eol        = 1'b0;
    eof        = 1'b0;
    // i_start wins in every state; a pixel on the same cycle is silently dropped
    if (i_start) begin
      clr_err = 1'b1;
      if (dims_ok) begin
        arm        = 1'b1;
        state_next = ARMED;
      end else begin
        state_next = IDLE;
      end
    end else begin
      case (state)
        IDLE: ovf = i_dvalid;
        ARMED, RUN: begin
          if (i_dvalid) begin
            fwd        = 1'b1;
            first      = (state == ARMED);
            eol        = last_x;
            eof        = last_x && last_y;
            state_next = eof ? IDLE : RUN;
          end else if (state == RUN && idle_cnt == TMO_LAST) begin
            tmo        = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      w_m1          <= '0;
      h_m1          <= '0;
      x             <= '0;
      y             <= '0;
      idle_cnt      <= '0;
      o_data        <= '0;
      o_dvalid      <= 1'b0;
      o_sof         <= 1'b0;
      o_eol         <= 1'b0;
      o_eof         <= 1'b0;
      o_done        <= 1'b0;
      o_err_ovf     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_line_cnt    <= '0;
    end else begin
      state    <= state_next;
      o_dvalid <= fwd;
      o_sof    <= first;
      o_eol    <= eol;
      o_eof    <= eof;
      o_done   <= eof;
      if (fwd) o_data <= i_data;

      if (clr_err) begin
        o_err_ovf     <= 1'b0;
        o_err_timeout <= 1'b0;
      end
      if (ovf) o_err_ovf <= 1'b1;
      if (tmo) o_err_timeout <= 1'b1;

      if (arm) begin
        w_m1       <= i_width - CW'(1);
        h_m1       <= i_height - CW'(1);
        x          <= '0;
        y          <= '0;
        o_line_cnt <= '0;
        idle_cnt   <= '0;
      end else if (fwd) begin
        idle_cnt <= '0;
        if (eol) begin
          x          <= '0;
          y          <= y + CW'(1);
          o_line_cnt <= o_line_cnt + CW'(1);
        end else begin
          x <= x + CW'(1);
        end
      end else if (state == RUN && !i_start) begin
        // a timeout leaves the counter parked at TIMEOUT until the next arm
        idle_cnt <= tmo ? TMO_SAT : idle_cnt + TW'(1);
      end
    end
  end

endmodule
